hist_count_pipeline: RTL and testbench

Parametrised histogram counting front end for the equaliser. It takes `NUM_WORDS` packed pixel words from the input memory (m1) and builds a `2^PIX_W`-bin histogram in a scratchpad bank (m2) at a selectable base offset. The bank is explicitly cleared before counting. The pipeline forwards same-bin hazards so every increment lands, and counts saturate instead of wrapping. It sits between the input memory and the CDF stage, which starts on `done`.

---
 rtl/hist_count_pipeline.sv | 197 +++++++++++++++++++
 tb/tb_hist_count_pipeline.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_count_pipeline.sv
// Histogram front end: clears a 2^PIX_W-bin bank in m2, then counts packed pixels from m1
// through a read-modify-write pipeline with same-bin forwarding and saturating counts.
module hist_count_pipeline #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int MEM_W        = 128,
    parameter int NUM_WORDS    = 4,
    parameter int CNT_W        = 16,
    parameter int ADDR_W       = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-PIX_W-1:0]  base_offset,
    output logic [ADDR_W-1:0]        m1ReadAddr,
    input  logic [MEM_W-1:0]         m1ReadVal,
    output logic [ADDR_W-1:0]        m2ReadAddr,
    input  logic [MEM_W-1:0]         m2ReadVal,
    output logic [ADDR_W-1:0]        m2WriteAddr,
    output logic [MEM_W-1:0]         m2WriteVal,
    output logic                     m2WE,
    output logic                     busy,
    output logic                     sat,
    output logic                     done
);

    localparam int NBINS  = 1 << PIX_W;
    localparam int NPIX   = NUM_WORDS * PIX_PER_WORD;
    localparam int BASE_W = ADDR_W - PIX_W;
    localparam int CYC_W  = $clog2(((NBINS > NPIX) ? NBINS : NPIX) + 1);
    localparam int PSEL_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    generate
        if (PIX_W * PIX_PER_WORD > MEM_W) begin : g_bad_packing
            $error("PIX_W*PIX_PER_WORD must not exceed MEM_W");
        end
        if (CNT_W > MEM_W) begin : g_bad_count_width
            $error("CNT_W must not exceed MEM_W");
        end
        if (ADDR_W <= PIX_W) begin : g_bad_addr_width
            $error("ADDR_W must be larger than PIX_W");
        end
    endgenerate

    logic [2:0]        state;
    logic [BASE_W-1:0] base;
    logic [CYC_W-1:0]  cyc;
    logic [ADDR_W-1:0] word_idx;
    logic [PSEL_W-1:0] pix_sel;

    logic              s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
    logic [PSEL_W-1:0] s1_sel;
    logic [PIX_W-1:0]  s2_pixel, s3_pixel, s4_pixel, s5_pixel;
    logic [CNT_W-1:0]  s4_count, s5_count;

    logic [PIX_W-1:0]  fetched_pixel;
    logic [CNT_W-1:0]  old_count, new_count;
    logic              at_max;
    logic              clearing;
    logic              unused_bits;

    assign unused_bits = ^{m1ReadVal, m2ReadVal};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            base     <= '0;
            cyc      <= '0;
            word_idx <= '0;
            pix_sel  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        base  <= base_offset;
                        cyc   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cyc == CYC_W'(NBINS - 1)) begin
                        state    <= S_COUNT;
                        cyc      <= '0;
                        word_idx <= '0;
                        pix_sel  <= '0;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                S_COUNT: begin
                    if (pix_sel == PSEL_W'(PIX_PER_WORD - 1)) begin
                        pix_sel  <= '0;
                        word_idx <= word_idx + ADDR_W'(1);
                    end else begin
                        pix_sel <= pix_sel + PSEL_W'(1);
                    end
                    if (cyc == CYC_W'(NPIX - 1)) begin
                        state <= S_DRAIN;
                        cyc   <= '0;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cyc == CYC_W'(3)) begin
                        state <= S_DONE;
                        cyc   <= '0;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                S_DONE: begin
                    if (!start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        fetched_pixel = m1ReadVal[int'(s1_sel) * PIX_W +: PIX_W];
    end

    // Pixel c-1 is being written this cycle and pixel c-2 landed on the same edge our read
    // was sampled, so neither is visible in m2ReadVal yet; the youngest match wins.
    always_comb begin
        old_count = m2ReadVal[CNT_W-1:0];
        if (s4_valid && (s4_pixel == s3_pixel)) begin
            old_count = s4_count;
        end else if (s5_valid && (s5_pixel == s3_pixel)) begin
            old_count = s5_count;
        end
        at_max    = (old_count == CNT_MAX);
        new_count = at_max ? old_count : old_count + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s5_valid <= 1'b0;
            s1_sel   <= '0;
            s2_pixel <= '0;
            s3_pixel <= '0;
            s4_pixel <= '0;
            s5_pixel <= '0;
            s4_count <= '0;
            s5_count <= '0;
            sat      <= 1'b0;
        end else begin
            s1_valid <= (state == S_COUNT);
            s1_sel   <= pix_sel;
            s2_valid <= s1_valid;
            s2_pixel <= fetched_pixel;
            s3_valid <= s2_valid;
            s3_pixel <= s2_pixel;
            s4_valid <= s3_valid;
            s4_pixel <= s3_pixel;
            s4_count <= new_count;
            s5_valid <= s4_valid;
            s5_pixel <= s4_pixel;
            s5_count <= s4_count;
            if ((state == S_IDLE) && start) begin
                sat <= 1'b0;
            end else if (s3_valid && at_max) begin
                sat <= 1'b1;
            end
        end
    end

    always_comb begin
        clearing    = (state == S_CLEAR);
        busy        = clearing || (state == S_COUNT) || (state == S_DRAIN);
        done        = (state == S_DONE);
        m1ReadAddr  = (state == S_COUNT) ? word_idx : '0;
        m2ReadAddr  = s2_valid ? {base, s2_pixel} : '0;
        m2WE        = clearing || s4_valid;
        m2WriteAddr = '0;
        m2WriteVal  = '0;
        if (clearing) begin
            m2WriteAddr = {base, cyc[PIX_W-1:0]};
        end else if (s4_valid) begin
            m2WriteAddr = {base, s4_pixel};
            m2WriteVal  = MEM_W'(s4_count);
        end
    end

endmodule

// File: tb/tb_hist_count_pipeline.sv
// Bench for hist_count_pipeline: memory models around two instances (default counts and a
// narrow-count one for saturation), checked against a plain-arithmetic histogram model.
module tb_hist_count_pipeline;

    localparam int PIX_W    = 8;
    localparam int PPW      = 16;
    localparam int MEM_W    = 128;
    localparam int NBINS    = 256;
    localparam int NW_A     = 4;
    localparam int ADDR_W_A = 16;
    localparam int CNT_W_A  = 16;
    localparam int NPIX_A   = 64;
    localparam int BW_A     = ADDR_W_A - PIX_W;
    localparam int JW_A     = MEM_W - CNT_W_A;
    localparam int NW_B     = 2;
    localparam int ADDR_W_B = 12;
    localparam int CNT_W_B  = 4;
    localparam int NPIX_B   = 32;
    localparam int BW_B     = ADDR_W_B - PIX_W;
    localparam int JW_B     = MEM_W - CNT_W_B;

    typedef struct {
        int                  cyc;
        logic [ADDR_W_A-1:0] addr;
        logic [MEM_W-1:0]    data;
    } wr_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic rst;

    logic                start_a;
    logic [BW_A-1:0]     base_a;
    logic [ADDR_W_A-1:0] m1ra_a, m2ra_a, m2wa_a;
    logic [MEM_W-1:0]    m1rv_a, m2rv_a, m2wv_a;
    logic                m2we_a, busy_a, sat_a, done_a;

    logic                start_b;
    logic [BW_B-1:0]     base_b;
    logic [ADDR_W_B-1:0] m1ra_b, m2ra_b, m2wa_b;
    logic [MEM_W-1:0]    m1rv_b, m2rv_b, m2wv_b;
    logic                m2we_b, busy_b, sat_b, done_b;

    logic [MEM_W-1:0] m1_mem_a [NW_A];
    logic [MEM_W-1:0] m2_mem_a [1 << ADDR_W_A];
    logic [MEM_W-1:0] m1_mem_b [NW_B];
    logic [MEM_W-1:0] m2_mem_b [1 << ADDR_W_B];
    logic [7:0]       pix_a [NPIX_A];
    logic [7:0]       pix_b [NPIX_B];

    logic            fill_a;
    logic [BW_A-1:0] fill_base_a;
    logic            cap_a;
    logic [BW_A-1:0] bank_a;
    int              cyc_a;
    int              oob_a;
    wr_t             mon_w;
    wr_t             wlog_a [$];

    hist_count_pipeline #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .MEM_W(MEM_W),
        .NUM_WORDS(NW_A), .CNT_W(CNT_W_A), .ADDR_W(ADDR_W_A)
    ) dut_a (
        .clock(clock), .rst(rst), .start(start_a), .base_offset(base_a),
        .m1ReadAddr(m1ra_a), .m1ReadVal(m1rv_a),
        .m2ReadAddr(m2ra_a), .m2ReadVal(m2rv_a),
        .m2WriteAddr(m2wa_a), .m2WriteVal(m2wv_a), .m2WE(m2we_a),
        .busy(busy_a), .sat(sat_a), .done(done_a)
    );

    hist_count_pipeline #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .MEM_W(MEM_W),
        .NUM_WORDS(NW_B), .CNT_W(CNT_W_B), .ADDR_W(ADDR_W_B)
    ) dut_b (
        .clock(clock), .rst(rst), .start(start_b), .base_offset(base_b),
        .m1ReadAddr(m1ra_b), .m1ReadVal(m1rv_b),
        .m2ReadAddr(m2ra_b), .m2ReadVal(m2rv_b),
        .m2WriteAddr(m2wa_b), .m2WriteVal(m2wv_b), .m2WE(m2we_b),
        .busy(busy_b), .sat(sat_b), .done(done_b)
    );

    // Synchronous-read memories; junk above the count field must be ignored by the DUT
    always @(posedge clock) begin
        m1rv_a <= (m1ra_a < ADDR_W_A'(NW_A)) ? m1_mem_a[m1ra_a[1:0]] : '0;
        m2rv_a <= {JW_A'({$urandom, $urandom, $urandom, $urandom}), m2_mem_a[m2ra_a][CNT_W_A-1:0]};
        if (fill_a) begin
            for (int i = 0; i < NBINS; i++) m2_mem_a[{fill_base_a, 8'(i)}] <= MEM_W'({$urandom, $urandom});
        end
        if (m2we_a) m2_mem_a[m2wa_a] <= m2wv_a;
    end

    always @(posedge clock) begin
        m1rv_b <= (m1ra_b < ADDR_W_B'(NW_B)) ? m1_mem_b[m1ra_b[0]] : '0;
        m2rv_b <= {JW_B'({$urandom, $urandom, $urandom, $urandom}), m2_mem_b[m2ra_b][CNT_W_B-1:0]};
        if (m2we_b) m2_mem_b[m2wa_b] <= m2wv_b;
    end

    always @(negedge clock) begin
        if (cap_a) begin
            cyc_a = cyc_a + 1;
            if (m2we_a) begin
                mon_w.cyc  = cyc_a;
                mon_w.addr = m2wa_a;
                mon_w.data = m2wv_a;
                wlog_a.push_back(mon_w);
                if (m2wa_a[ADDR_W_A-1:PIX_W] != bank_a) oob_a++;
            end
            if ((m2ra_a != '0) && (m2ra_a[ADDR_W_A-1:PIX_W] != bank_a)) oob_a++;
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [BW_A-1:0] base, input bit pulse_start, input int abort_at);
        int done_k;
        for (int w = 0; w < NW_A; w++)
            for (int p = 0; p < PPW; p++) m1_mem_a[w][p*PIX_W +: PIX_W] = pix_a[w*PPW + p];
        fill_base_a = base;
        @(posedge clock); #1 fill_a = 1'b1;
        @(posedge clock); #1 fill_a = 1'b0;
        wlog_a.delete();
        oob_a   = 0;
        bank_a  = base;
        cyc_a   = -2;
        cap_a   = 1'b1;
        base_a  = base;
        start_a = 1'b1;
        done_k  = -1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clock); #1;
            if ((abort_at >= 0) && (k == NBINS + abort_at)) begin
                checkOutput("busy_before_rst", busy_a, 1'b1);
                rst = 1'b1;
                #1;
                checkOutput("rst_m1ReadAddr", m1ra_a, '0);
                checkOutput("rst_m2ReadAddr", m2ra_a, '0);
                checkOutput("rst_m2WriteAddr", m2wa_a, '0);
                checkOutput("rst_m2WriteVal", m2wv_a, '0);
                checkOutput("rst_flags", {m2we_a, busy_a, sat_a, done_a}, 4'b0000);
                rst     = 1'b0;
                start_a = 1'b0;
                cap_a   = 1'b0;
                return;
            end
            if (pulse_start) begin
                if (k == 50)  start_a = 1'b0;
                if (k == 100) start_a = 1'b1;
                if (k == 101) start_a = 1'b0;
            end
            if (done_a) begin
                done_k = k;
                break;
            end
        end
        checkOutput("done_cycle", done_k, NBINS + NPIX_A + 4);
        if (pulse_start) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clock); #1;
                checkOutput("idle_after_pulse", {done_a, busy_a, m2we_a}, 3'b000);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clock); #1;
                checkOutput("done_hold", {done_a, busy_a}, 2'b10);
            end
            start_a = 1'b0;
            @(posedge clock); #1;
            checkOutput("done_release", {done_a, busy_a}, 2'b00);
        end
        cap_a = 1'b0;
    endtask

    task automatic checkHistogram(input logic [BW_A-1:0] base);
        int   hist [NBINS];
        wr_t  w;
        logic [7:0] p;
        for (int b = 0; b < NBINS; b++) hist[b] = 0;
        checkOutput("write_count", wlog_a.size(), NBINS + NPIX_A);
        for (int k = 0; (k < NBINS) && (k < wlog_a.size()); k++) begin
            w = wlog_a[k];
            checkOutput($sformatf("clear_wr%0d", k), {w.cyc, w.addr, w.data}, {k, {base, 8'(k)}, MEM_W'(0)});
        end
        for (int c = 0; c < NPIX_A; c++) begin
            p = pix_a[c];
            if (hist[p] < 65535) hist[p] = hist[p] + 1;
            if (NBINS + c < wlog_a.size()) begin
                w = wlog_a[NBINS + c];
                checkOutput($sformatf("pixel_wr%0d", c), {w.cyc, w.addr, w.data},
                            {NBINS + c + 4, {base, p}, MEM_W'(hist[p])});
            end
        end
        for (int b = 0; b < NBINS; b++)
            checkOutput($sformatf("bin%0d", b), m2_mem_a[{base, 8'(b)}], MEM_W'(hist[b]));
        checkOutput("out_of_bank", oob_a, 0);
        checkOutput("sat_a", sat_a, 1'b0);
    endtask

    task automatic applyStimulusSat(input logic [BW_B-1:0] base);
        int done_k;
        int hist [NBINS];
        bit exp_sat;
        for (int w = 0; w < NW_B; w++)
            for (int p = 0; p < PPW; p++) m1_mem_b[w][p*PIX_W +: PIX_W] = pix_b[w*PPW + p];
        base_b  = base;
        start_b = 1'b1;
        done_k  = -1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clock); #1;
            if (k == 0) checkOutput("sat_cleared_on_start", sat_b, 1'b0);
            if (done_b) begin
                done_k = k;
                break;
            end
        end
        checkOutput("done_cycle_b", done_k, NBINS + NPIX_B + 4);
        for (int b = 0; b < NBINS; b++) hist[b] = 0;
        exp_sat = 1'b0;
        for (int c = 0; c < NPIX_B; c++) begin
            if (hist[pix_b[c]] == 15) exp_sat = 1'b1;
            else hist[pix_b[c]] = hist[pix_b[c]] + 1;
        end
        for (int b = 0; b < NBINS; b++)
            checkOutput($sformatf("b_bin%0d", b), m2_mem_b[{base, 8'(b)}], MEM_W'(hist[b]));
        checkOutput("sat_b", sat_b, exp_sat);
        start_b = 1'b0;
        @(posedge clock); #1;
        checkOutput("done_release_b", done_b, 1'b0);
    endtask

    initial begin
        logic [7:0]      pa, pb;
        logic [BW_A-1:0] rb;
        rst         = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        base_a      = '0;
        base_b      = '0;
        fill_a      = 1'b0;
        fill_base_a = '0;
        cap_a       = 1'b0;
        bank_a      = '0;
        cyc_a       = 0;
        oob_a       = 0;
        #2;
        checkOutput("reset_addr", {m1ra_a, m2ra_a, m2wa_a}, '0);
        checkOutput("reset_data", m2wv_a, '0);
        checkOutput("reset_flags", {m2we_a, busy_a, sat_a, done_a}, 4'b0000);
        @(posedge clock); #1 rst = 1'b0;

        $display("[TB] all-zero image");
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = 8'h00;
        applyStimulus(8'h00, 1'b0, -1);
        checkHistogram(8'h00);

        $display("[TB] ascending image in bank 3");
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = 8'(i);
        applyStimulus(8'h03, 1'b0, -1);
        checkHistogram(8'h03);

        $display("[TB] alternating A,B");
        pa = 8'($urandom_range(0, 255));
        pb = pa + 8'($urandom_range(1, 255));
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = (i % 2 == 0) ? pa : pb;
        rb = 8'($urandom_range(0, 255));
        applyStimulus(rb, 1'b0, -1);
        checkHistogram(rb);

        $display("[TB] repeating A,A,B,A");
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = (i % 4 == 2) ? pb : pa;
        applyStimulus(rb, 1'b0, -1);
        checkHistogram(rb);

        $display("[TB] random image with start pulses while busy");
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = 8'($urandom_range(0, 15));
        rb = 8'($urandom_range(0, 255));
        applyStimulus(rb, 1'b1, -1);
        checkHistogram(rb);

        $display("[TB] reset during count, then restart");
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = 8'($urandom_range(0, 7));
        applyStimulus(rb, 1'b0, 10);
        for (int i = 0; i < NPIX_A; i++) pix_a[i] = 8'($urandom_range(0, 255));
        applyStimulus(rb, 1'b0, -1);
        checkHistogram(rb);

        $display("[TB] saturation with 4-bit counts");
        for (int i = 0; i < NPIX_B; i++) pix_b[i] = (i < 20) ? 8'h7F : 8'h01;
        applyStimulusSat(4'h2);
        for (int i = 0; i < NPIX_B; i++) pix_b[i] = 8'(i);
        applyStimulusSat(4'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
